// File: rtl/traffic_light_ctrl_param.sv
// Main/side-road junction controller: latched side request, all-red clearance,
// side-green extension capped at a maximum, and a maintenance flash mode.
//
//  state        | meaning
//  -------------+-----------------------------------------------------------
//  MAIN_GREEN   | main road served; holds until min green done and req latched
//  MAIN_YELLOW  | main road yellow for YELLOW_TIME cycles
//  ALL_RED_A    | clearance before side road is served; clears req on exit
//  SIDE_GREEN   | side road served; min green, extended by i_Vs up to max
//  SIDE_YELLOW  | side road yellow for YELLOW_TIME cycles
//  ALL_RED_B    | clearance before main road (also the exit path from FLASH)
//  FLASH        | maintenance: main yellow / side red blink together
module traffic_light_ctrl_param #(
   parameter int CNT_W          = 8,
   parameter int MAIN_MIN_GREEN = 20,
   parameter int YELLOW_TIME    = 3,
   parameter int ALL_RED_TIME   = 2,
   parameter int SIDE_MIN_GREEN = 10,
   parameter int SIDE_MAX_GREEN = 20,
   parameter int FLASH_HALF     = 4
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_Vs,
   input  logic       i_flash,
   output logic       o_Main_red,
   output logic       o_Main_yellow,
   output logic       o_Main_green,
   output logic       o_Side_red,
   output logic       o_Side_yellow,
   output logic       o_Side_green,
   output logic [2:0] o_state,
   output logic       o_req_pending
);

   typedef enum logic [2:0] {
      MAIN_GREEN  = 3'd0,
      MAIN_YELLOW = 3'd1,
      ALL_RED_A   = 3'd2,
      SIDE_GREEN  = 3'd3,
      SIDE_YELLOW = 3'd4,
      ALL_RED_B   = 3'd5,
      FLASH       = 3'd6
   } state_t;

   // Phase timer counts down from (duration-1); terminal count is zero.
   localparam logic [CNT_W-1:0] LD_MAIN   = CNT_W'(MAIN_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_TIME - 1);
   localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALL_RED_TIME - 1);
   localparam logic [CNT_W-1:0] LD_SIDE   = CNT_W'(SIDE_MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] LD_FLASH  = CNT_W'(FLASH_HALF - 1);
   // Side green has served its minimum once the remaining count drops to this.
   localparam logic [CNT_W-1:0] SIDE_SLACK = CNT_W'(SIDE_MAX_GREEN - SIDE_MIN_GREEN);

   state_t           state_q, state_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             req_q, req_nxt;
   logic             blink_q, blink_nxt;
   logic [5:0]       lamp_q;
   logic             cnt_tc;

   // {main_red, main_yellow, main_green, side_red, side_yellow, side_green}
   function automatic logic [5:0] lamps_of(input state_t s, input logic b);
      logic [5:0] l;
      l = 6'b001_100;
      case (s)
         MAIN_GREEN:            l = 6'b001_100;
         MAIN_YELLOW:           l = 6'b010_100;
         ALL_RED_A, ALL_RED_B:  l = 6'b100_100;
         SIDE_GREEN:            l = 6'b100_001;
         SIDE_YELLOW:           l = 6'b100_010;
         FLASH:                 l = {1'b0, b, 1'b0, b, 2'b00};
         default:               l = 6'b001_100;
      endcase
      return l;
   endfunction

   assign cnt_tc = (cnt_q == '0);

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_tc ? cnt_q : cnt_q - 1'b1;
      blink_nxt = blink_q;
      req_nxt   = req_q | (i_Vs && (state_q != SIDE_GREEN));

      if (i_flash && (state_q != FLASH)) begin
         state_nxt = FLASH;
         cnt_nxt   = LD_FLASH;
         blink_nxt = 1'b1;
      end else begin
         case (state_q)
            MAIN_GREEN: begin
               if (cnt_tc && req_q) begin
                  state_nxt = MAIN_YELLOW;
                  cnt_nxt   = LD_YELLOW;
               end
            end
            MAIN_YELLOW: begin
               if (cnt_tc) begin
                  state_nxt = ALL_RED_A;
                  cnt_nxt   = LD_ALLRED;
               end
            end
            ALL_RED_A: begin
               if (cnt_tc) begin
                  state_nxt = SIDE_GREEN;
                  cnt_nxt   = LD_SIDE;
                  req_nxt   = 1'b0;
               end
            end
            SIDE_GREEN: begin
               if (cnt_tc || ((cnt_q <= SIDE_SLACK) && !i_Vs)) begin
                  state_nxt = SIDE_YELLOW;
                  cnt_nxt   = LD_YELLOW;
               end
            end
            SIDE_YELLOW: begin
               if (cnt_tc) begin
                  state_nxt = ALL_RED_B;
                  cnt_nxt   = LD_ALLRED;
               end
            end
            ALL_RED_B: begin
               if (cnt_tc) begin
                  state_nxt = MAIN_GREEN;
                  cnt_nxt   = LD_MAIN;
               end
            end
            FLASH: begin
               if (!i_flash) begin
                  state_nxt = ALL_RED_B;
                  cnt_nxt   = LD_ALLRED;
               end else if (cnt_tc) begin
                  blink_nxt = ~blink_q;
                  cnt_nxt   = LD_FLASH;
               end
            end
            default: begin
               state_nxt = MAIN_GREEN;
               cnt_nxt   = LD_MAIN;
            end
         endcase
      end
   end

   // Lamps are registered from the next state so they change on the same edge as o_state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= MAIN_GREEN;
         cnt_q   <= LD_MAIN;
         req_q   <= 1'b0;
         blink_q <= 1'b1;
         lamp_q  <= lamps_of(MAIN_GREEN, 1'b1);
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         req_q   <= req_nxt;
         blink_q <= blink_nxt;
         lamp_q  <= lamps_of(state_nxt, blink_nxt);
      end
   end

   assign {o_Main_red, o_Main_yellow, o_Main_green,
           o_Side_red, o_Side_yellow, o_Side_green} = lamp_q;
   assign o_state       = state_q;
   assign o_req_pending = req_q;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Bench for traffic_light_ctrl_param: directed junction scenarios plus random traffic,
// checked each cycle by a scoreboard against a phase/elapsed-time reference model.
module tb_traffic_light_ctrl_param;

   localparam int P_MAIN  = 20;
   localparam int P_YEL   = 3;
   localparam int P_RED   = 2;
   localparam int P_SMIN  = 10;
   localparam int P_SMAX  = 20;
   localparam int P_FLASH = 4;

   logic       i_clk = 1'b0;
   logic       i_reset, i_Vs, i_flash;
   logic       o_Main_red, o_Main_yellow, o_Main_green;
   logic       o_Side_red, o_Side_yellow, o_Side_green;
   logic [2:0] o_state;
   logic       o_req_pending;

   traffic_light_ctrl_param dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_Vs          (i_Vs),
      .i_flash       (i_flash),
      .o_Main_red    (o_Main_red),
      .o_Main_yellow (o_Main_yellow),
      .o_Main_green  (o_Main_green),
      .o_Side_red    (o_Side_red),
      .o_Side_yellow (o_Side_yellow),
      .o_Side_green  (o_Side_green),
      .o_state       (o_state),
      .o_req_pending (o_req_pending)
   );

   always #5 i_clk = ~i_clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_cyc   = 0;

   // Reference model: phase number, cycles already spent in phase, request latch, blink.
   int m_phase;
   int m_t;
   bit m_req;
   bit m_blink;

   logic [9:0] exp_q[$];

   task automatic model_step(input bit v, input bit f, input bit r);
      int el, np;
      bit clr, restart;
      if (r) begin
         m_phase = 0; m_t = 0; m_req = 0; m_blink = 1;
         return;
      end
      el = m_t + 1; np = m_phase; clr = 0; restart = 0;
      if (f && m_phase != 6) begin
         np = 6; m_blink = 1;
      end else begin
         case (m_phase)
            0: if (el >= P_MAIN && m_req) np = 1;
            1: if (el >= P_YEL) np = 2;
            2: if (el >= P_RED) begin np = 3; clr = 1; end
            3: if ((el >= P_SMIN && !v) || el >= P_SMAX) np = 4;
            4: if (el >= P_YEL) np = 5;
            5: if (el >= P_RED) np = 0;
            6: if (!f) np = 5;
               else if (el >= P_FLASH) begin m_blink = !m_blink; restart = 1; end
            default: np = 0;
         endcase
      end
      m_req = clr ? 1'b0 : (m_req | (v && m_phase != 3));
      if (np != m_phase || restart) m_t = 0;
      else if (m_t < 255) m_t = m_t + 1;
      m_phase = np;
   endtask

   function automatic logic [9:0] model_expect();
      logic [5:0] l;
      case (m_phase)
         0: l = 6'b001_100;
         1: l = 6'b010_100;
         2, 5: l = 6'b100_100;
         3: l = 6'b100_001;
         4: l = 6'b100_010;
         default: l = {1'b0, m_blink, 1'b0, m_blink, 2'b00};
      endcase
      return {3'(m_phase), m_req, l};
   endfunction

   // Drive one cycle of inputs, push the response expected after the coming edge.
   task automatic step(input bit v, input bit f, input bit r);
      i_Vs = v; i_flash = f; i_reset = r;
      model_step(v, f, r);
      exp_q.push_back(model_expect());
      @(posedge i_clk);
      #1;
   endtask

   task automatic run(input int n, input bit v);
      for (int k = 0; k < n; k++) step(v, 1'b0, 1'b0);
   endtask

   task automatic run_until(input int ph, input bit v, input int max);
      for (int k = 0; k < max && m_phase != ph; k++) step(v, 1'b0, 1'b0);
   endtask

   // Monitor: every cycle the DUT presents a fresh lamp/state set.
   initial begin
      logic [9:0] e, got;
      forever begin
         @(negedge i_clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {o_state, o_req_pending, o_Main_red, o_Main_yellow, o_Main_green,
                   o_Side_red, o_Side_yellow, o_Side_green};
            n_cyc++;
            n_tests++;
            if (got !== e) begin
               n_fail++;
               $display("FAIL outputs cyc=%0d got state=%0d req=%b lamps=%b exp state=%0d req=%b lamps=%b",
                        n_cyc, got[9:7], got[6], got[5:0], e[9:7], e[6], e[5:0]);
            end
            if (o_state != 3'd6) begin
               n_tests++;
               if ($countones({o_Main_red, o_Main_yellow, o_Main_green}) != 1 ||
                   $countones({o_Side_red, o_Side_yellow, o_Side_green}) != 1) begin
                  n_fail++;
                  $display("FAIL one_lamp cyc=%0d got main=%b side=%b exp one lamp each",
                           n_cyc, {o_Main_red, o_Main_yellow, o_Main_green},
                           {o_Side_red, o_Side_yellow, o_Side_green});
               end
            end
         end
      end
   end

   initial begin
      bit fl;
      // T1: idle main green
      step(0, 0, 1);
      step(0, 0, 1);
      run(100, 0);
      // T2: single request pulse at main-green cycle 5
      step(0, 0, 1);
      run(4, 0);
      step(1, 0, 0);
      run(60, 0);
      // T3: request then hold sensor through side green
      run(30, 1);
      run(40, 1);
      run(30, 0);
      // T4: request during side yellow
      step(1, 0, 0);
      run_until(4, 0, 200);
      step(1, 0, 0);
      run(70, 0);
      // T5: flash mid side green, then release
      step(1, 0, 0);
      run_until(3, 0, 200);
      run(3, 1);
      for (int k = 0; k < 20; k++) step(0, 1, 0);
      run(30, 0);
      // T6: reset in main yellow and in flash
      step(1, 0, 0);
      run_until(1, 0, 200);
      step(0, 0, 1);
      run(5, 0);
      for (int k = 0; k < 7; k++) step(0, 1, 0);
      step(0, 1, 1);
      run(10, 0);
      // Random traffic with occasional flash and reset
      fl = 0;
      for (int k = 0; k < 4000; k++) begin
         if (!fl && $urandom_range(0, 299) == 0) fl = 1;
         else if (fl && $urandom_range(0, 24) == 0) fl = 0;
         step(($urandom_range(0, 5) == 0), fl, ($urandom_range(0, 599) == 0));
      end
      run(5, 0);
      @(negedge i_clk);
      #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d pending exp 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
